// File: rtl/data_mem_lsu.sv
// Byte-addressable RV32 data memory with sub-word load/store, a one-cycle
// req/resp handshake, fault reporting and an optional post-reset clear.
module data_mem_lsu #(
    parameter int DEPTH          = 1024,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        err,
    output logic        init_done
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic            ready_q, ready_d;
    logic            init_done_q, init_done_d;
    logic            resp_valid_q, resp_valid_d;
    logic            err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;

    logic [31:0]     mem [DEPTH];

    logic [AW-1:0]   widx;
    logic [1:0]      lane;
    logic [1:0]      size;
    logic            uns;
    logic            fault;
    logic            accept;
    logic            st_en;
    logic            clr_en;
    logic [3:0]      st_be;
    logic [31:0]     st_data;
    logic [31:0]     rd_word;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [31:0]     ld_ext;

    assign widx   = addr[AW+1:2];
    assign lane   = addr[1:0];
    assign size   = funct3[1:0];
    assign uns    = funct3[2];
    assign accept = ready_q && req;
    assign st_en  = accept && we && !fault;
    assign clr_en = CLEAR_ON_RESET && (state_q == ST_INIT);

    // Decode faults, store lane enables/data and the extended load value.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        fault   = 1'b0;
        st_be   = 4'b0000;
        st_data = wdata;
        ld_ext  = 32'd0;

        if ((addr >> (AW + 2)) != 32'd0)                    fault = 1'b1;
        if (size == 2'b11)                                  fault = 1'b1;
        if (uns && (we || size == 2'b10))                   fault = 1'b1;
        if (size == 2'b01 && addr[0])                       fault = 1'b1;
        if (size == 2'b10 && lane != 2'b00)                 fault = 1'b1;

        rd_word = mem[widx];
        ld_byte = rd_word[8*lane +: 8];
        ld_half = addr[1] ? rd_word[31:16] : rd_word[15:0];

        case (size)
            2'b00: begin
                st_be   = 4'b0001 << lane;
                st_data = {4{wdata[7:0]}};
                ld_ext  = uns ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            end
            2'b01: begin
                st_be   = addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{wdata[15:0]}};
                ld_ext  = uns ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = wdata;
                ld_ext  = rd_word;
            end
        endcase
    end

    // Next-state logic for the INIT/RUN sequencer and the response registers.
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        ready_d      = ready_q;
        init_done_d  = init_done_q;
        resp_valid_d = accept;
        err_d        = accept && fault;
        rdata_d      = rdata_q;

        if (accept) begin
            rdata_d = (we || fault) ? 32'd0 : ld_ext;
        end

        case (state_q)
            ST_INIT: begin
                if (CLEAR_ON_RESET) begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                    if (clr_cnt_q == AW'(DEPTH - 1)) begin
                        state_d     = ST_RUN;
                        ready_d     = 1'b1;
                        init_done_d = 1'b1;
                    end
                end else begin
                    state_d     = ST_RUN;
                    ready_d     = 1'b1;
                    init_done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Control and response registers, cleared asynchronously by rst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_INIT;
            clr_cnt_q    <= '0;
            ready_q      <= 1'b0;
            init_done_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= 32'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            ready_q      <= ready_d;
            init_done_q  <= init_done_d;
            resp_valid_q <= resp_valid_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
        end
    end

    // Storage array: clear sequencer writes zeros, stores write enabled lanes.
    // NOTE: the array has no reset; the clear sequencer zeroes it instead so it maps to RAM.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_cnt_q] <= 32'd0;
        end else if (st_en) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i]) mem[widx][8*i +: 8] <= st_data[8*i +: 8];
            end
        end
    end

    assign ready      = ready_q;
    assign resp_valid = resp_valid_q;
    assign rdata      = rdata_q;
    assign err        = err_q;
    assign init_done  = init_done_q;

endmodule
